// File: rtl/sdram_ctrl.sv
// SDRAM command controller: mode-register program, ACTIVATE, burst READ/WRITE, PRECHARGE.
// Data buses stay outside; EnWData/EnRData tell the host when data moves.
module sdram_ctrl (
    input  logic        clock,
    input  logic        bar_reset,
    input  logic        Status,
    input  logic        Write,
    input  logic [2:0]  Burst,
    input  logic [31:0] Addr_32,
    input  logic [9:0]  ProgramData,
    output logic        Ready,
    output logic        EnWData,
    output logic        EnRData,
    output logic        bar_CS,
    output logic        bar_RAS,
    output logic        bar_CAS,
    output logic        bar_WE,
    output logic [1:0]  BS,
    output logic [9:0]  A,
    output logic [2:0]  state,
    output logic [3:0]  CountOut
);

    typedef enum logic [2:0] {
        S_PROGRAM   = 3'd0,
        S_IDLE      = 3'd1,
        S_ACTIVATE  = 3'd2,
        S_READ      = 3'd3,
        S_WRITE     = 3'd4,
        S_PRECHARGE = 3'd5
    } state_t;

    // {CS, RAS, CAS, WE}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    state_t     st;
    logic [3:0] cmd;

    logic [2:0] t_pre;
    logic [2:0] t_cas;
    logic [3:0] t_wait;

    logic       req_write;
    logic [2:0] req_burst;
    logic [1:0] req_bank;
    logic [9:0] req_col;

    logic [3:0] cnt_dec;
    logic [3:0] burst_len;
    logic       unused_bits;

    assign {bar_CS, bar_RAS, bar_CAS, bar_WE} = cmd;
    assign state       = st;
    assign cnt_dec     = CountOut - 4'd1;
    assign burst_len   = {1'b0, req_burst} + 4'd1;
    assign unused_bits = ^{Addr_32[31:22], ProgramData[9:7]};

    always_ff @(posedge clock) begin
        if (!bar_reset) begin
            st        <= S_PROGRAM;
            cmd       <= CMD_DESEL;
            Ready     <= 1'b0;
            EnWData   <= 1'b0;
            EnRData   <= 1'b0;
            BS        <= 2'd0;
            A         <= 10'd0;
            CountOut  <= 4'd0;
            t_pre     <= 3'd1;
            t_cas     <= 3'd1;
            t_wait    <= 4'd1;
            req_write <= 1'b0;
            req_burst <= 3'd0;
            req_bank  <= 2'd0;
            req_col   <= 10'd0;
        end else begin
            cmd <= CMD_NOP;
            case (st)
                // The reset cycle leaves DESEL on the pins; the first cycle out of reset
                // is the MRS, the next one moves to IDLE.
                S_PROGRAM: begin
                    if (cmd == CMD_DESEL) begin
                        cmd    <= CMD_MRS;
                        A      <= ProgramData;
                        BS     <= 2'd0;
                        t_pre  <= {1'b0, ProgramData[1:0]} + 3'd1;
                        t_cas  <= {1'b0, ProgramData[3:2]} + 3'd1;
                        t_wait <= {1'b0, ProgramData[6:4]} + 4'd1;
                    end else begin
                        st    <= S_IDLE;
                        Ready <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (Status) begin
                        req_write <= Write;
                        req_burst <= Burst;
                        req_bank  <= Addr_32[21:20];
                        req_col   <= Addr_32[9:0];
                        cmd       <= CMD_ACT;
                        BS        <= Addr_32[21:20];
                        A         <= Addr_32[19:10];
                        CountOut  <= {1'b0, t_pre};
                        Ready     <= 1'b0;
                        st        <= S_ACTIVATE;
                    end
                end

                S_ACTIVATE: begin
                    if (CountOut == 4'd1) begin
                        A  <= req_col;
                        BS <= req_bank;
                        if (req_write) begin
                            cmd      <= CMD_WR;
                            CountOut <= burst_len;
                            EnWData  <= 1'b1;
                            st       <= S_WRITE;
                        end else begin
                            // read data arrives tCAS cycles after RD, then streams burst_len beats
                            cmd      <= CMD_RD;
                            CountOut <= {1'b0, t_cas} + burst_len;
                            EnRData  <= 1'b0;
                            st       <= S_READ;
                        end
                    end else begin
                        CountOut <= cnt_dec;
                    end
                end

                S_WRITE, S_READ: begin
                    if (CountOut == 4'd1) begin
                        cmd      <= CMD_PRE;
                        BS       <= req_bank;
                        A        <= 10'd0;
                        CountOut <= t_wait;
                        EnWData  <= 1'b0;
                        EnRData  <= 1'b0;
                        st       <= S_PRECHARGE;
                    end else begin
                        CountOut <= cnt_dec;
                        EnWData  <= (st == S_WRITE);
                        EnRData  <= (st == S_READ) && (cnt_dec <= burst_len);
                    end
                end

                S_PRECHARGE: begin
                    if (CountOut == 4'd1) begin
                        CountOut <= 4'd0;
                        Ready    <= 1'b1;
                        st       <= S_IDLE;
                    end else begin
                        CountOut <= cnt_dec;
                    end
                end

                default: begin
                    CountOut <= 4'd0;
                    EnWData  <= 1'b0;
                    EnRData  <= 1'b0;
                    Ready    <= 1'b1;
                    st       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed + randomized bench for sdram_ctrl; each transaction is expanded into an
// expected per-cycle trace from the timing fields and compared at the falling edge.
module tb_sdram_ctrl;

    logic        clock = 1'b0;
    logic        bar_reset = 1'b0;
    logic        Status = 1'b0;
    logic        Write = 1'b0;
    logic [2:0]  Burst = 3'd0;
    logic [31:0] Addr_32 = 32'd0;
    logic [9:0]  ProgramData = 10'd0;
    logic        Ready, EnWData, EnRData;
    logic        bar_CS, bar_RAS, bar_CAS, bar_WE;
    logic [1:0]  BS;
    logic [9:0]  A;
    logic [2:0]  state;
    logic [3:0]  CountOut;

    int checks = 0;
    int errors = 0;
    int tp = 1, tc = 1, tw = 1;

    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [3:0] ACT   = 4'b0011;
    localparam logic [3:0] RD    = 4'b0101;
    localparam logic [3:0] WR    = 4'b0100;
    localparam logic [3:0] PRE   = 4'b0010;
    localparam logic [3:0] MRS   = 4'b0000;
    localparam logic [3:0] DESEL = 4'b1111;

    sdram_ctrl dut (
        .clock(clock), .bar_reset(bar_reset), .Status(Status), .Write(Write),
        .Burst(Burst), .Addr_32(Addr_32), .ProgramData(ProgramData),
        .Ready(Ready), .EnWData(EnWData), .EnRData(EnRData),
        .bar_CS(bar_CS), .bar_RAS(bar_RAS), .bar_CAS(bar_CAS), .bar_WE(bar_WE),
        .BS(BS), .A(A), .state(state), .CountOut(CountOut)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: negative values for cnt/bs/a mean "don't care this cycle".
    task automatic cyc(input string tag, input int st, input logic [3:0] cm, input bit rdy,
                       input bit ew, input bit er, input int cnt, input int bs, input int a);
        @(negedge clock);
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " cmd"}, 32'({bar_CS, bar_RAS, bar_CAS, bar_WE}), 32'(cm));
        chk({tag, " Ready"}, 32'(Ready), 32'(rdy));
        chk({tag, " EnWData"}, 32'(EnWData), 32'(ew));
        chk({tag, " EnRData"}, 32'(EnRData), 32'(er));
        if (cnt >= 0) chk({tag, " CountOut"}, 32'(CountOut), 32'(cnt));
        if (bs >= 0)  chk({tag, " BS"}, 32'(BS), 32'(bs));
        if (a >= 0)   chk({tag, " A"}, 32'(A), 32'(a));
    endtask

    task automatic do_reset(input logic [9:0] pd);
        Status = 1'b0;
        bar_reset = 1'b0;
        ProgramData = pd;
        cyc("reset", 0, DESEL, 0, 0, 0, 0, 0, 0);
        bar_reset = 1'b1;
        cyc("mrs", 0, MRS, 0, 0, 0, -1, 0, int'(pd));
        tp = int'(pd[1:0]) + 1;
        tc = int'(pd[3:2]) + 1;
        tw = int'(pd[6:4]) + 1;
        ProgramData = 10'($urandom);
        cyc("prog_idle", 1, NOP, 1, 0, 0, -1, -1, -1);
    endtask

    task automatic idle_cycles(input int n);
        Status = 1'b0;
        for (int i = 0; i < n; i++) begin
            ProgramData = 10'($urandom);
            cyc("idle", 1, NOP, 1, 0, 0, -1, -1, -1);
        end
    endtask

    // Entered at a falling edge where IDLE/Ready=1 was just observed.
    // abort>0 returns after that many cycles of the transaction.
    task automatic do_txn(input bit wr, input logic [2:0] b, input logic [31:0] addr,
                          input bit keep, input int abort);
        int bank, row, col, bl, la, lx, lp, k, cnt, st;
        logic [3:0] cm;
        bit er;
        bank = int'(addr[21:20]);
        row  = int'(addr[19:10]);
        col  = int'(addr[9:0]);
        bl   = int'(b) + 1;
        la   = tp;
        lx   = wr ? bl : tc + bl;
        lp   = tw;
        Status = 1'b1; Write = wr; Burst = b; Addr_32 = addr;
        for (int i = 0; i < la + lx + lp; i++) begin
            er = 1'b0;
            if (i < la) begin
                k = i; st = 2; cnt = la - k;
                cm = (k == 0) ? ACT : NOP;
                cyc("activate", st, cm, 0, 0, 0, cnt, k == 0 ? bank : -1, k == 0 ? row : -1);
            end else if (i < la + lx) begin
                k = i - la; st = wr ? 4 : 3; cnt = lx - k;
                cm = (k == 0) ? (wr ? WR : RD) : NOP;
                er = !wr && (cnt <= bl);
                cyc(wr ? "write" : "read", st, cm, 0, wr, er, cnt,
                    k == 0 ? bank : -1, k == 0 ? col : -1);
            end else begin
                k = i - la - lx; st = 5; cnt = lp - k;
                cm = (k == 0) ? PRE : NOP;
                cyc("precharge", st, cm, 0, 0, 0, cnt, k == 0 ? bank : -1, k == 0 ? 0 : -1);
            end
            if (i == 0) begin
                Status  = keep;
                Write   = 1'($urandom);
                Burst   = 3'($urandom);
                Addr_32 = $urandom;
            end
            if (abort != 0 && i + 1 == abort) return;
        end
        cyc("back_idle", 1, NOP, 1, 0, 0, -1, -1, -1);
    endtask

    initial begin
        bit keep;
        do_reset(10'h014);
        chk("tPRE", 32'(tp), 32'd1);
        chk("tCAS", 32'(tc), 32'd2);
        chk("tWAIT", 32'(tw), 32'd2);
        idle_cycles(2);

        do_txn(1'b1, 3'd7, 32'h0000_03FF, 1'b0, 0);
        idle_cycles(1);
        do_txn(1'b0, 3'd3, 32'h0010_0405, 1'b0, 0);
        idle_cycles(1);

        // Status held through the whole transaction: exactly one IDLE cycle, then next ACT
        do_txn(1'b1, 3'd2, 32'h0023_4567, 1'b1, 0);
        do_txn(1'b0, 3'd1, 32'hFFF0_0C0A, 1'b0, 0);
        idle_cycles(1);

        for (int n = 0; n < 12; n++) begin
            if (n % 4 == 3) do_reset(10'($urandom));
            keep = ($urandom_range(0, 3) == 0);
            do_txn(1'($urandom), 3'($urandom), $urandom, keep, 0);
            if (!keep) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(1);

        do_reset(10'h07F);
        chk("max tPRE", 32'(tp), 32'd4);
        chk("max tCAS", 32'(tc), 32'd4);
        chk("max tWAIT", 32'(tw), 32'd8);
        do_txn(1'b0, 3'd7, 32'h0031_5A5A, 1'b0, 0);
        do_txn(1'b1, 3'd0, 32'h0000_0001, 1'b0, 0);
        idle_cycles(1);

        // Reset in the middle of a read burst, while EnRData is active
        do_reset(10'h014);
        do_txn(1'b0, 3'd5, 32'h0020_1234, 1'b0, tp + tc + 2);
        do_reset(10'h025);
        do_txn(1'b1, 3'd4, 32'h0012_3456, 1'b0, 0);
        idle_cycles(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
